firebird7_in_gate1_tessent_tdr_data_ctrl: RTL and testbench

- IJTAG test data register (TDR) that drives the select and override-data side of the gate1 w3 data mux.
- Captures the functional data value for observation, shifts on the IJTAG scan path, and updates a shadow register.
- The shadow register produces ijtag_select and ijtag_data_out for the mux.
- Sits on the gate1 IJTAG network behind a SIB, clocked by ijtag_tck.

---
 rtl/firebird7_in_gate1_tessent_tdr_pkg.sv | 24 ++
 rtl/firebird7_in_gate1_tessent_tdr_data_ctrl.sv | 58 +++++
 tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared constants and types for the gate1 w3 data-mux IJTAG TDR.
package firebird7_in_gate1_tessent_tdr_pkg;

    // Default override/functional data width of the gate1 w3 mux.
    localparam int TDR_DATA_W = 3;

    // Scan length: one select bit above the data bits.
    localparam int TDR_LEN = TDR_DATA_W + 1;

    // Position of the select bit inside the scan/update word.
    localparam int SEL_BIT = TDR_DATA_W;

    // Scan/update word as seen by the mux: {select, data}.
    typedef struct packed {
        logic                  select;
        logic [TDR_DATA_W-1:0] data;
    } tdr_word_t;

    // Scan length for an arbitrary data width.
    function automatic int tdr_len(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl.sv
// IJTAG TDR for the gate1 w3 data mux: captures functional data, shifts on
// the scan path and drives the mux select/override data from an update
// register loaded on the falling edge of ijtag_tck.
module firebird7_in_gate1_tessent_tdr_data_ctrl
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int               WIDTH        = TDR_DATA_W,
    parameter logic [WIDTH-1:0] RESET_DATA   = {WIDTH{1'b0}},
    parameter logic             RESET_SELECT = 1'b0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_obs,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out
);

    // sr[WIDTH] is the select bit, sr[WIDTH-1:0] the data bits.
    logic [tdr_len(WIDTH)-1:0] sr;
    logic                      upd_select;
    logic [WIDTH-1:0]          upd_data;

    // Capture/shift register; capture has priority over shift, and the
    // current update select is recaptured so it can be read back.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr <= '0;
        end else if (ijtag_sel && ijtag_ce) begin
            sr <= {upd_select, functional_data_obs};
        end else if (ijtag_sel && ijtag_se) begin
            sr <= {ijtag_si, sr[WIDTH:1]};
        end
    end

    // Update register on the falling edge so outputs settle half a tck
    // after ue is seen, away from the shift edge.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            upd_select <= RESET_SELECT;
            upd_data   <= RESET_DATA;
        end else if (ijtag_sel && ijtag_ue) begin
            upd_select <= sr[WIDTH];
            upd_data   <= sr[WIDTH-1:0];
        end
    end

    // Outputs come straight from flops: no retiming, no glitch logic.
    assign ijtag_so       = sr[0];
    assign ijtag_select   = upd_select;
    assign ijtag_data_out = upd_data;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl.sv
// Directed bench for the gate1 w3 data-mux IJTAG TDR.
module tb_firebird7_in_gate1_tessent_tdr_data_ctrl;
    import firebird7_in_gate1_tessent_tdr_pkg::*;

    logic                  ijtag_tck = 1'b0;
    logic                  ijtag_reset;
    logic                  ijtag_sel;
    logic                  ijtag_ce;
    logic                  ijtag_se;
    logic                  ijtag_ue;
    logic                  ijtag_si;
    logic                  ijtag_so;
    logic [TDR_DATA_W-1:0] functional_data_obs;
    logic                  ijtag_select;
    logic [TDR_DATA_W-1:0] ijtag_data_out;

    int errors = 0;
    int checks = 0;

    firebird7_in_gate1_tessent_tdr_data_ctrl #(
        .WIDTH        (TDR_DATA_W),
        .RESET_DATA   ({TDR_DATA_W{1'b0}}),
        .RESET_SELECT (1'b0)
    ) dut (
        .ijtag_tck           (ijtag_tck),
        .ijtag_reset         (ijtag_reset),
        .ijtag_sel           (ijtag_sel),
        .ijtag_ce            (ijtag_ce),
        .ijtag_se            (ijtag_se),
        .ijtag_ue            (ijtag_ue),
        .ijtag_si            (ijtag_si),
        .ijtag_so            (ijtag_so),
        .functional_data_obs (functional_data_obs),
        .ijtag_select        (ijtag_select),
        .ijtag_data_out      (ijtag_data_out)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the {select, data} pair driven to the mux.
    task automatic check_out(input string tag, input tdr_word_t expected);
        tdr_word_t observed;
        observed.select = ijtag_select;
        observed.data   = ijtag_data_out;
        check(tag, 32'(observed), 32'(expected));
    endtask

    task automatic shift_bit(input logic b);
        ijtag_se = 1'b1;
        ijtag_si = b;
        @(posedge ijtag_tck); #1;
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
    endtask

    task automatic capture(input logic [TDR_DATA_W-1:0] obs);
        ijtag_ce = 1'b1;
        functional_data_obs = obs;
        @(posedge ijtag_tck); #1;
        ijtag_ce = 1'b0;
    endtask

    task automatic update();
        ijtag_ue = 1'b1;
        @(negedge ijtag_tck); #1;
        ijtag_ue = 1'b0;
    endtask

    initial begin
        ijtag_reset = 1'b0;
        ijtag_sel = 1'b0;
        ijtag_ce = 1'b0;
        ijtag_se = 1'b0;
        ijtag_ue = 1'b0;
        ijtag_si = 1'b0;
        functional_data_obs = '0;

        // Power-on reset state.
        #3;
        check_out("por_out", '{select: 1'b0, data: 3'b000});
        check("por_so", 32'(ijtag_so), 32'd0);
        @(posedge ijtag_tck); #1;
        ijtag_reset = 1'b1;
        ijtag_sel = 1'b1;

        // Load 1/111 so the asynchronous reset has something to clear.
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
        check("ones_so", 32'(ijtag_so), 32'd1);
        update();
        check_out("ones_out", '{select: 1'b1, data: 3'b111});
        @(posedge ijtag_tck); #2;
        ijtag_reset = 1'b0;
        #1;
        check_out("async_rst_out", '{select: 1'b0, data: 3'b000});
        check("async_rst_so", 32'(ijtag_so), 32'd0);
        @(posedge ijtag_tck); #1;
        ijtag_reset = 1'b1;

        // Shift 1,0,1,1 then update: sr = 1101.
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
        check_out("pre_ue_out3", '{select: 1'b0, data: 3'b000});
        shift_bit(1'b1);
        check_out("pre_ue_out4", '{select: 1'b0, data: 3'b000});
        check("shift_so", 32'(ijtag_so), 32'd1);
        update();
        check_out("shift_upd_out", '{select: 1'b1, data: 3'b101});

        // Capture 110 with upd_select = 1: sr = 1110, so reads 0,1,1,1,0.
        @(posedge ijtag_tck); #1;
        capture(3'b110);
        check("cap_so0", 32'(ijtag_so), 32'd0);
        shift_bit(1'b0);
        check("cap_so1", 32'(ijtag_so), 32'd1);
        shift_bit(1'b0);
        check("cap_so2", 32'(ijtag_so), 32'd1);
        shift_bit(1'b0);
        check("cap_so3", 32'(ijtag_so), 32'd1);
        shift_bit(1'b0);
        check("long_shift_so", 32'(ijtag_so), 32'd0);
        check_out("cap_no_ue_out", '{select: 1'b1, data: 3'b101});

        // Update straight after capture: override = observed, select held.
        capture(3'b010);
        update();
        check_out("cap_upd_out", '{select: 1'b1, data: 3'b010});

        // One shift of 1 leaves sr = 1101 pending, outputs still 1/010.
        @(posedge ijtag_tck); #1;
        shift_bit(1'b1);
        check("pend_so", 32'(ijtag_so), 32'd1);

        // sel low: ce/se/ue with si = 1 must change nothing.
        ijtag_sel = 1'b0;
        ijtag_ce = 1'b1;
        ijtag_se = 1'b1;
        ijtag_ue = 1'b1;
        ijtag_si = 1'b1;
        functional_data_obs = 3'b000;
        for (int i = 0; i < 8; i++) begin
            @(posedge ijtag_tck); #1;
        end
        check("nosel_so", 32'(ijtag_so), 32'd1);
        check_out("nosel_out", '{select: 1'b1, data: 3'b010});
        ijtag_ce = 1'b0;
        ijtag_se = 1'b0;
        ijtag_ue = 1'b0;
        ijtag_si = 1'b0;
        ijtag_sel = 1'b1;
        update();
        check_out("nosel_kept_sr", '{select: 1'b1, data: 3'b101});

        // Clear, then ce & se together: capture wins, si ignored.
        @(posedge ijtag_tck); #2;
        ijtag_reset = 1'b0;
        #1;
        ijtag_reset = 1'b1;
        @(posedge ijtag_tck); #1;
        ijtag_ce = 1'b1;
        ijtag_se = 1'b1;
        ijtag_si = 1'b1;
        functional_data_obs = 3'b011;
        @(posedge ijtag_tck); #1;
        ijtag_ce = 1'b0;
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
        check("cese_so", 32'(ijtag_so), 32'd1);
        update();
        check_out("cese_out", '{select: 1'b0, data: 3'b011});

        // Reset in the middle of a scan, then a clean 0,1,0,1 scan.
        @(posedge ijtag_tck); #1;
        shift_bit(1'b1); shift_bit(1'b1);
        #1;
        ijtag_reset = 1'b0;
        #1;
        check_out("midrst_out", '{select: 1'b0, data: 3'b000});
        check("midrst_so", 32'(ijtag_so), 32'd0);
        ijtag_reset = 1'b1;
        @(posedge ijtag_tck); #1;
        shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
        check("midrst_scan_so", 32'(ijtag_so), 32'd0);
        update();
        check_out("midrst_scan_out", '{select: 1'b1, data: 3'b010});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
